// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule constants, rcon table and sequencer state encoding
package aes_pkg;
    localparam int NR = 10;
    localparam int KW = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [31:0] rcon_of(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1B;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction
endpackage

// File: rtl/key_expansion.sv
// key_expansion: one combinational AES-128 key-schedule step (next round key from current key + rcon)
// Ports: rcon {rc,24'h0}; key current round key (w0 in [127:96]); expanded_key next round key.
module key_expansion (
    input  logic [31:0]  rcon,
    input  logic [127:0] key,
    output logic [127:0] expanded_key
);
    // FIPS-197 S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    logic [31:0] rot, temp, n0, n1, n2, n3;

    // RotWord then SubWord on the last word, then fold in rcon.
    assign rot  = {key[23:0], key[31:24]};
    assign temp = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
                   sub_byte(rot[15:8]), sub_byte(rot[7:0])} ^ rcon;
    assign n0 = key[127:96] ^ temp;
    assign n1 = key[95:64]  ^ n0;
    assign n2 = key[63:32]  ^ n1;
    assign n3 = key[31:0]   ^ n2;
    assign expanded_key = {n0, n1, n2, n3};
endmodule

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: sequences AES-128 key expansion, stores round keys 0..NR and streams them out
// Ports: clk/rst_n (sync active-low); start/key_in launch a schedule from IDLE;
//        busy, done, keys_ready status; rk_valid/rk_idx/rk_data stream each new round key;
//        rd_addr/rd_data combinational register-file read (0 beyond NR).
module key_sched_ctrl
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    output logic          busy,
    output logic          done,
    output logic          rk_valid,
    output logic [3:0]    rk_idx,
    output logic [KW-1:0] rk_data,
    input  logic [3:0]    rd_addr,
    output logic [KW-1:0] rd_data,
    output logic          keys_ready
);
    state_t        state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic [KW-1:0] cur_key_q, cur_key_d;
    logic          rk_valid_q, rk_valid_d;
    logic [3:0]    rk_idx_q, rk_idx_d;
    logic [KW-1:0] rk_data_q, rk_data_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic [KW-1:0] rf_q [0:NR];
    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [KW-1:0] wr_data;
    logic [31:0]   rcon;
    logic [KW-1:0] exp_key;

    assign rcon = rcon_of(round_q);

    // Step input comes only from the registered working key, so no loop is formed.
    key_expansion u_step (
        .rcon         (rcon),
        .key          (cur_key_q),
        .expanded_key (exp_key)
    );

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        cur_key_d  = cur_key_q;
        rk_valid_d = 1'b0;
        rk_idx_d   = rk_idx_q;
        rk_data_d  = rk_data_q;
        done_d     = 1'b0;
        ready_d    = ready_q;
        wr_en      = 1'b0;
        wr_idx     = round_q;
        wr_data    = exp_key;
        case (state_q)
            IDLE: if (start) begin
                state_d    = EXPAND;
                round_d    = 4'd1;
                cur_key_d  = key_in;
                rk_valid_d = 1'b1;
                rk_idx_d   = 4'd0;
                rk_data_d  = key_in;
                ready_d    = 1'b0;
                wr_en      = 1'b1;
                wr_idx     = 4'd0;
                wr_data    = key_in;
            end
            EXPAND: begin
                cur_key_d  = exp_key;
                rk_valid_d = 1'b1;
                rk_idx_d   = round_q;
                rk_data_d  = exp_key;
                wr_en      = 1'b1;
                round_d    = round_q + 4'd1;
                state_d    = (round_q == 4'(NR)) ? DONE : EXPAND;
            end
            DONE: begin
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            round_q    <= '0;
            cur_key_q  <= '0;
            rk_valid_q <= 1'b0;
            rk_idx_q   <= '0;
            rk_data_q  <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            for (int i = 0; i <= NR; i++) rf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            cur_key_q  <= cur_key_d;
            rk_valid_q <= rk_valid_d;
            rk_idx_q   <= rk_idx_d;
            rk_data_q  <= rk_data_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            if (wr_en) rf_q[wr_idx] <= wr_data;
        end
    end

    assign busy       = (state_q == EXPAND);
    assign done       = done_q;
    assign rk_valid   = rk_valid_q;
    assign rk_idx     = rk_idx_q;
    assign rk_data    = rk_data_q;
    assign keys_ready = ready_q;
    assign rd_data    = (rd_addr <= 4'(NR)) ? rf_q[rd_addr] : '0;
endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb_key_sched_ctrl: directed + randomized checks of key_sched_ctrl against a FIPS-197 word-recurrence model
module tb_key_sched_ctrl;
    logic         clk = 1'b0;
    logic         rst_n, start;
    logic [127:0] key_in;
    logic         busy, done, rk_valid, keys_ready;
    logic [3:0]   rk_idx, rd_addr;
    logic [127:0] rk_data, rd_data;

    always #5 clk = ~clk;

    key_sched_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .rk_valid   (rk_valid),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .keys_ready (keys_ready)
    );

    int           passed = 0;
    int           total  = 0;
    logic [7:0]   sb [256];
    logic [7:0]   rc [11];
    logic [127:0] exp_rk [11];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Key schedule as the standard 44-word recurrence, regrouped into 11 round keys.
    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rc[i/4], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic launch(input logic [127:0] k);
        build_model(k);
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
        key_in = rnd128();
    endtask

    // Checks cycles 1..12 after an accepted start; optionally raises start at cycle inj.
    task automatic stream(input int inj, input logic [127:0] other);
        for (int c = 1; c <= 11; c++) begin
            chk($sformatf("rk_valid c%0d", c), 128'(rk_valid), 128'(1));
            chk($sformatf("rk_idx c%0d", c), 128'(rk_idx), 128'(c - 1));
            chk($sformatf("rk_data c%0d", c), rk_data, exp_rk[c-1]);
            chk($sformatf("done c%0d", c), 128'(done), 128'(0));
            chk($sformatf("busy c%0d", c), 128'(busy), 128'(c <= 10));
            if (c <= 10) chk($sformatf("rcon c%0d", c), 128'(dut.rcon), 128'({rc[c], 24'h0}));
            if (c == 1) chk("keys_ready cleared", 128'(keys_ready), 128'(0));
            start = (c == inj);
            if (c == inj) key_in = other;
            tick();
        end
        start = 1'b0;
        chk("done c12", 128'(done), 128'(1));
        chk("keys_ready c12", 128'(keys_ready), 128'(1));
        chk("rk_valid c12", 128'(rk_valid), 128'(0));
        chk("busy c12", 128'(busy), 128'(0));
    endtask

    task automatic post();
        tick();
        chk("done single pulse", 128'(done), 128'(0));
        chk("busy idle after done", 128'(busy), 128'(0));
        chk("rk_valid idle after done", 128'(rk_valid), 128'(0));
    endtask

    task automatic readback(input bit zero);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            chk($sformatf("rd_data[%0d]", a), rd_data, (a <= 10 && !zero) ? exp_rk[a] : 128'h0);
        end
    endtask

    initial begin
        logic [127:0] k;
        rst_n   = 1'b0;
        start   = 1'b0;
        key_in  = '0;
        rd_addr = '0;
        rc[0] = 8'h00;
        rc[1] = 8'h01;
        for (int i = 2; i <= 10; i++) rc[i] = gmul(rc[i-1], 8'h02);
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int c = 1; c < 256; c++) if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        // Reset and idle
        repeat (3) tick();
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset done", 128'(done), 128'(0));
        chk("reset keys_ready", 128'(keys_ready), 128'(0));
        chk("reset rk_valid", 128'(rk_valid), 128'(0));
        readback(1'b1);
        rst_n = 1'b1;
        tick();
        // All-zero key
        launch(128'h0);
        stream(0, 128'h0);
        post();
        readback(1'b0);
        rd_addr = 4'd1;
        #1;
        chk("zero key rk1 literal", rd_data, 128'h62636363626363636263636362636363);
        // FIPS-197 key, with an ignored start while busy
        tick();
        launch(128'h2B7E151628AED2A6ABF7158809CF4F3C);
        stream(5, rnd128());
        post();
        readback(1'b0);
        rd_addr = 4'd10;
        #1;
        chk("fips rk10 literal", rd_data, 128'hD014F9A8C9EE2589E13F0CC8B6630CA6);
        // Start during DONE is ignored; back-to-back start on first IDLE cycle is accepted
        tick();
        launch(rnd128());
        stream(11, rnd128());
        launch(rnd128());
        stream(0, 128'h0);
        post();
        readback(1'b0);
        // Reset mid-expansion at round 6
        tick();
        launch(rnd128());
        repeat (5) tick();
        chk("round 6 busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        tick();
        chk("mid reset busy", 128'(busy), 128'(0));
        chk("mid reset rk_valid", 128'(rk_valid), 128'(0));
        chk("mid reset keys_ready", 128'(keys_ready), 128'(0));
        readback(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("no done after reset %0d", i), 128'(done), 128'(0));
        end
        // Normal completion after reset
        k = rnd128();
        launch(k);
        stream(0, 128'h0);
        post();
        readback(1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/key_sched_ctrl.md
Name: key_sched_ctrl

Overview:
- Sequencer for the combinational AES-128 key-expansion step (`key_expansion`: rcon[31:0], key[127:0] -> expanded_key[127:0]).
- On start, latches a cipher key and iterates the step once per clock for 10 rounds, supplying the correct rcon each round.
- Stores round keys 0..10 in an internal 11-entry register file. The cipher round engine reads them by index.
- Also streams each round key out with a valid strobe as it is produced.

Parameters:
- NR, 10, number of expansion rounds (AES-128); register file depth is NR+1.
- KW, 128, round-key width in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to expand key_in; sampled only in IDLE.
- key_in  in  KW  cipher key (round key 0), sampled on the accepted start cycle.
- busy  out  1  high while expansion is in progress.
- done  out  1  one-cycle pulse when round key NR has been written.
- rk_valid  out  1  one-cycle strobe: rk_data/rk_idx hold a newly written round key.
- rk_idx  out  4  index of the round key on rk_data (0..NR).
- rk_data  out  KW  streamed round key.
- rd_addr  in  4  register-file read index.
- rd_data  out  KW  combinational read of entry rd_addr; returns 0 if rd_addr > NR.
- keys_ready  out  1  high when all NR+1 entries are valid for the current key.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - state = IDLE; busy = 0, done = 0, rk_valid = 0.
  - rk_idx = 0, rk_data = 0, keys_ready = 0, round counter = 0.
  - All register-file entries = 0.
- IDLE state:
  - busy = 0.
  - On start = 1: write key_in to entry 0 and to the working register cur_key.
  - Assert rk_valid with rk_idx = 0 and rk_data = key_in.
  - Clear keys_ready, set round = 1, go to EXPAND.
- EXPAND state:
  - busy = 1. Each cycle: cur_key <= expanded_key and entry[round] <= expanded_key.
  - Assert rk_valid with rk_idx = round and rk_data = expanded_key.
  - Increment round.
  - When round == NR: go to DONE.
- DONE state:
  - Single cycle. done = 1, keys_ready <= 1, busy = 0.
  - Return to IDLE.
- Latency: round key k is written k+1 clocks after the accepted start (k = 0..NR). done is asserted NR+2 cycles after start, i.e. the cycle after the key-10 write.
- rcon is driven combinationally from round: {rc[round], 24'h0}. rc[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. round 0 and round > 10 give 0.
- The step input is cur_key; the step output is registered only by this block. There is no combinational loop.
- start while busy or in DONE: ignored. No queueing, no restart.
- start in the same cycle that DONE returns to IDLE: ignored. It is accepted on the next IDLE cycle.
- rd_data during expansion: returns the current stored contents, which may be stale or partial. Consumers must wait for keys_ready.
- A new accepted start clears keys_ready in the same edge and overwrites entries progressively.
- rst_n low mid-expansion: the next edge forces IDLE and clears every register and entry. No done pulse is produced.
- rk_valid and done are never both high in the same cycle.

Decomposition:
- Shared package aes_pkg:
  - Round-count constant NR = 10 and key width KW = 128.
  - The rc byte table as a constant function rcon_of(round) returning the 32-bit {rc, 24'h0}.
  - State encoding (IDLE, EXPAND, DONE) as a 2-bit typedef.
- Sub-module: one instance of the existing `key_expansion` combinational step. The register file stays inline; it is too small to warrant a separate module.

Test Plan:
- Reset, then idle: rst_n low for 3 cycles, start = 0 -> busy = 0, done = 0, keys_ready = 0, rd_data = 0 for all addresses 0..15.
- All-zero key: start with key_in = 0 ->
  - rk_valid on cycle 1 with rk_idx = 0, rk_data = 0.
  - Cycle 2 with rk_idx = 1, rk_data = 62636363_62636363_62636363_62636363.
  - done on cycle 12; rd_data(1) matches.
- Rcon sequencing: key_in = 2B7E1516_28AED2A6_ABF71588_09CF4F3C -> each rk_data[k] equals the golden model of the step applied to rk_data[k-1] with rcon {rc[k], 24'h0}. Assert rcon = 1B000000 at round 9 and 36000000 at round 10.
- Start while busy: second start with a different key at cycle 5 -> ignored. All 11 entries match the first key; exactly one done pulse.
- Back-to-back: a new start on the first IDLE cycle after done ->
  - Accepted; keys_ready drops on the same edge.
  - The new schedule is fully written 12 cycles later.
- Reset mid-expansion: rst_n low at round 6 -> the next cycle has busy = 0, all entries = 0, and no done pulse. A subsequent start completes normally.
